// File: rtl/median_pkg.sv
// Shared constants for the median filter blocks: FSM encoding and 5-tap median geometry.
package median_pkg;

  localparam int unsigned MED_TAPS = 5;
  localparam int unsigned MED_IDX  = 2;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StUpdate  = 2'd1;
  localparam logic [1:0] StCompute = 2'd2;
  localparam logic [1:0] StOut     = 2'd3;

endpackage

// File: rtl/median5.sv
// Combinational 5-input median: odd-even transposition sort, middle element returned.
module median5
  import median_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [MED_TAPS*DW-1:0] taps,
  output logic [DW-1:0]          med
);

  // Five alternating rounds of compare-exchange fully sort five values.
  localparam int unsigned NumCmp = 10;
  localparam int unsigned PairLo [NumCmp] = '{0, 2, 1, 3, 0, 2, 1, 3, 0, 2};
  localparam int unsigned PairHi [NumCmp] = '{1, 3, 2, 4, 1, 3, 2, 4, 1, 3};

  logic [DW-1:0] v [MED_TAPS];
  logic [DW-1:0] t;

  always_comb begin
    t = '0;
    for (int unsigned i = 0; i < MED_TAPS; i++) begin
      v[i] = taps[i*DW +: DW];
    end
    for (int unsigned p = 0; p < NumCmp; p++) begin
      if (v[PairLo[p]] > v[PairHi[p]]) begin
        t             = v[PairLo[p]];
        v[PairLo[p]]  = v[PairHi[p]];
        v[PairHi[p]]  = t;
      end
    end
    med = v[MED_IDX];
  end

endmodule

// File: rtl/median_mux_sched.sv
// Round-robin scheduler sharing one 5-tap median engine across NUM_CH sample channels,
// each with its own 5-sample history.
module median_mux_sched
  import median_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DW     = 8,
  parameter int unsigned CHW    = 2
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 Enable,
  input  logic                 clr,
  input  logic [NUM_CH-1:0]    in_valid,
  input  logic [NUM_CH*DW-1:0] in_data,
  output logic [NUM_CH-1:0]    in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [CHW-1:0]       out_ch,
  output logic                 busy
);

  logic [1:0]     state_q, state_d;
  logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [DW-1:0]  sample_q, sample_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic [CHW-1:0] out_ch_q, out_ch_d;

  logic [DW-1:0]  hist_q [NUM_CH][MED_TAPS];

  logic           grant_found;
  logic [CHW-1:0] grant_ch;
  logic           do_grant;
  logic           do_clr;

  logic [MED_TAPS*DW-1:0] med_taps;
  logic [DW-1:0]          med_val;

  // First requester at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_found && in_valid[(int'(rr_ptr_q) + i) % NUM_CH]) begin
        grant_found = 1'b1;
        grant_ch    = CHW'((int'(rr_ptr_q) + i) % NUM_CH);
      end
    end
  end

  assign do_clr   = (state_q == StIdle) && clr;
  assign do_grant = (state_q == StIdle) && !clr && Enable && grant_found;
  assign in_ready = do_grant ? (NUM_CH'(1) << grant_ch) : '0;

  always_comb begin
    med_taps = '0;
    for (int unsigned j = 0; j < MED_TAPS; j++) begin
      med_taps[j*DW +: DW] = hist_q[ch_q][j];
    end
  end

  median5 #(
    .DW (DW)
  ) u_median5 (
    .taps (med_taps),
    .med  (med_val)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    ch_d        = ch_q;
    sample_d    = sample_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    case (state_q)
      StIdle: begin
        if (do_grant) begin
          ch_d     = grant_ch;
          sample_d = in_data[int'(grant_ch)*DW +: DW];
          rr_ptr_d = (grant_ch == CHW'(NUM_CH - 1)) ? '0 : grant_ch + CHW'(1);
          state_d  = StUpdate;
        end
      end
      StUpdate: begin
        state_d = StCompute;
      end
      StCompute: begin
        out_data_d  = med_val;
        out_ch_d    = ch_q;
        out_valid_d = 1'b1;
        state_d     = StOut;
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      ch_q        <= '0;
      sample_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      ch_q        <= ch_d;
      sample_q    <= sample_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        for (int j = 0; j < MED_TAPS; j++) begin
          hist_q[k][j] <= '0;
        end
      end
    end else if (do_clr) begin
      for (int k = 0; k < NUM_CH; k++) begin
        for (int j = 0; j < MED_TAPS; j++) begin
          hist_q[k][j] <= '0;
        end
      end
    end else if (state_q == StUpdate) begin
      for (int j = MED_TAPS - 1; j > 0; j--) begin
        hist_q[ch_q][j] <= hist_q[ch_q][j-1];
      end
      hist_q[ch_q][0] <= sample_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign busy      = (state_q != StIdle);

endmodule
